// File: rtl/prpg10_chk.sv
// Receive-end checker for the x^10 + x^3 + 1 PRPG stream: acquires lock from
// incoming words, then free-runs a local predictor and counts word/bit errors.
module prpg10_chk #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 4,
   parameter int ERRCNT_W   = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                ChkEnable,
   input  logic                ChkClear,
   input  logic [9:0]          PrpgIn,
   input  logic                PrpgInValid,
   output logic                ChkLocked,
   output logic                ChkErr,
   output logic [ERRCNT_W-1:0] ChkErrWordCnt,
   output logic [ERRCNT_W-1:0] ChkErrBitCnt
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

   localparam int                  SUM_W      = ERRCNT_W + 1;
   localparam logic [3:0]          LOCK_TGT   = 4'(LOCK_CNT);
   localparam logic [3:0]          UNLOCK_TGT = 4'(UNLOCK_CNT);
   localparam logic [ERRCNT_W-1:0] CNT_MAX    = '1;

   state_t              state, state_nx;
   logic [9:0]          pred, pred_nx;
   logic                have_pred, have_pred_nx;
   logic [3:0]          match_cnt, match_cnt_nx;
   logic [3:0]          miss_cnt, miss_cnt_nx;
   logic                err_nx;
   logic [ERRCNT_W-1:0] word_cnt_nx, bit_cnt_nx;
   logic [SUM_W-1:0]    bit_sum;

   function automatic logic [9:0] lfsr_next(input logic [9:0] w);
      return {w[8:0], w[9] ^ w[2]};
   endfunction

   function automatic logic [3:0] popcount10(input logic [9:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 10; i++) c = c + 4'(v[i]);
      return c;
   endfunction

   assign bit_sum = {1'b0, ChkErrBitCnt} + SUM_W'(popcount10(PrpgIn ^ pred));

   // NOTE: every next-state variable gets a hold default first so no latch is inferred.
   always_comb begin
      state_nx     = state;
      pred_nx      = pred;
      have_pred_nx = have_pred;
      match_cnt_nx = match_cnt;
      miss_cnt_nx  = miss_cnt;
      err_nx       = 1'b0;
      word_cnt_nx  = ChkErrWordCnt;
      bit_cnt_nx   = ChkErrBitCnt;

      unique case (state)
         IDLE: if (ChkEnable) state_nx = ACQ;
         ACQ: begin
            if (PrpgInValid) begin
               if (PrpgIn == 10'd0) begin
                  // All-zero is the LFSR lock-up state and can never be part of a stream.
                  match_cnt_nx = '0;
                  have_pred_nx = 1'b0;
               end else begin
                  match_cnt_nx = (have_pred && PrpgIn == pred) ? match_cnt + 4'd1 : 4'd0;
                  pred_nx      = lfsr_next(PrpgIn);
                  have_pred_nx = 1'b1;
                  if (match_cnt_nx == LOCK_TGT) begin
                     state_nx    = LOCK;
                     miss_cnt_nx = '0;
                  end
               end
            end
         end
         LOCK: begin
            if (PrpgInValid) begin
               pred_nx = lfsr_next(pred);
               if (PrpgIn == pred) begin
                  miss_cnt_nx = '0;
               end else begin
                  err_nx      = 1'b1;
                  word_cnt_nx = (ChkErrWordCnt == CNT_MAX) ? CNT_MAX
                                                           : ChkErrWordCnt + ERRCNT_W'(1);
                  bit_cnt_nx  = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[ERRCNT_W-1:0];
                  miss_cnt_nx = miss_cnt + 4'd1;
                  if (miss_cnt_nx == UNLOCK_TGT) begin
                     state_nx     = ACQ;
                     match_cnt_nx = '0;
                     have_pred_nx = 1'b0;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      if (!ChkEnable) begin
         state_nx     = IDLE;
         pred_nx      = pred;
         have_pred_nx = 1'b0;
         match_cnt_nx = '0;
         miss_cnt_nx  = '0;
         err_nx       = 1'b0;
         word_cnt_nx  = ChkErrWordCnt;
         bit_cnt_nx   = ChkErrBitCnt;
      end

      if (ChkClear) begin
         word_cnt_nx = '0;
         bit_cnt_nx  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         pred          <= '0;
         have_pred     <= 1'b0;
         match_cnt     <= '0;
         miss_cnt      <= '0;
         ChkLocked     <= 1'b0;
         ChkErr        <= 1'b0;
         ChkErrWordCnt <= '0;
         ChkErrBitCnt  <= '0;
      end else begin
         state         <= state_nx;
         pred          <= pred_nx;
         have_pred     <= have_pred_nx;
         match_cnt     <= match_cnt_nx;
         miss_cnt      <= miss_cnt_nx;
         ChkLocked     <= (state_nx == LOCK);
         ChkErr        <= err_nx;
         ChkErrWordCnt <= word_cnt_nx;
         ChkErrBitCnt  <= bit_cnt_nx;
      end
   end

endmodule

// File: tb/tb_prpg10_chk.sv
// Directed + randomized bench for prpg10_chk; two instances (16-bit and 4-bit
// counters) share stimulus and are compared against one behavioural model.
module tb_prpg10_chk;

   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 4;

   logic       clk = 1'b0;
   logic       rst, en, clr, valid;
   logic [9:0] win;
   logic       lk16, er16, lk4, er4;
   logic [15:0] wc16, bc16;
   logic [3:0]  wc4, bc4;

   always #5 clk = ~clk;

   prpg10_chk #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERRCNT_W(16)) u16 (
      .Clk(clk), .Reset(rst), .ChkEnable(en), .ChkClear(clr), .PrpgIn(win),
      .PrpgInValid(valid), .ChkLocked(lk16), .ChkErr(er16),
      .ChkErrWordCnt(wc16), .ChkErrBitCnt(bc16));

   prpg10_chk #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERRCNT_W(4)) u4 (
      .Clk(clk), .Reset(rst), .ChkEnable(en), .ChkClear(clr), .PrpgIn(win),
      .PrpgInValid(valid), .ChkLocked(lk4), .ChkErr(er4),
      .ChkErrWordCnt(wc4), .ChkErrBitCnt(bc4));

   // Behavioural model: error totals are unbounded integers, saturation applied on readout.
   bit         m_active, m_locked, m_have, m_err;
   logic [9:0] m_pred;
   int         m_match, m_miss, m_words, m_bits;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc_no   = 0;
   logic [9:0] tx;

   function automatic logic [9:0] nxt(input logic [9:0] w);
      int v, fb;
      v  = int'(w);
      fb = ((v >> 9) ^ (v >> 2)) & 1;
      return 10'(((v * 2) % 1024) + fb);
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_active = 0; m_locked = 0; m_have = 0; m_err = 0;
      m_pred = '0; m_match = 0; m_miss = 0; m_words = 0; m_bits = 0;
   endtask

   task automatic model_step(input bit e, input bit c, input bit v, input logic [9:0] w);
      logic [9:0] expw;
      m_err = 0;
      if (!e) begin
         m_active = 0; m_locked = 0; m_have = 0; m_match = 0; m_miss = 0;
      end else if (!m_active) begin
         m_active = 1;
      end else if (v) begin
         if (!m_locked) begin
            if (w == 10'd0) begin
               m_match = 0; m_have = 0;
            end else begin
               m_match = (m_have && w == m_pred) ? m_match + 1 : 0;
               m_pred  = nxt(w);
               m_have  = 1;
               if (m_match == LOCK_CNT) begin
                  m_locked = 1; m_miss = 0;
               end
            end
         end else begin
            expw   = m_pred;
            m_pred = nxt(m_pred);
            if (w == expw) m_miss = 0;
            else begin
               m_err = 1;
               m_words++;
               m_bits += $countones(w ^ expw);
               m_miss++;
               if (m_miss == UNLOCK_CNT) begin
                  m_locked = 0; m_match = 0; m_have = 0;
               end
            end
         end
      end
      if (c) begin
         m_words = 0; m_bits = 0;
      end
   endtask

   task automatic check_outputs();
      check($sformatf("cyc%0d.lk16", cyc_no), 32'(lk16), 32'(m_locked));
      check($sformatf("cyc%0d.er16", cyc_no), 32'(er16), 32'(m_err));
      check($sformatf("cyc%0d.wc16", cyc_no), 32'(wc16), sat(m_words, 65535));
      check($sformatf("cyc%0d.bc16", cyc_no), 32'(bc16), sat(m_bits, 65535));
      check($sformatf("cyc%0d.lk4", cyc_no),  32'(lk4),  32'(m_locked));
      check($sformatf("cyc%0d.er4", cyc_no),  32'(er4),  32'(m_err));
      check($sformatf("cyc%0d.wc4", cyc_no),  32'(wc4),  sat(m_words, 15));
      check($sformatf("cyc%0d.bc4", cyc_no),  32'(bc4),  sat(m_bits, 15));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'($urandom); clr = 1'($urandom); valid = 1'($urandom);
      win = 10'($urandom);
      @(posedge clk);
      cyc_no++;
      model_reset();
      #1 check_outputs();
   endtask

   task automatic cyc(input bit e, input bit c, input bit v, input logic [9:0] w);
      @(negedge clk);
      rst = 1'b0; en = e; clr = c; valid = v; win = w;
      @(posedge clk);
      cyc_no++;
      model_step(e, c, v, w);
      #1 check_outputs();
   endtask

   task automatic good();
      cyc(1, 0, 1, tx);
      tx = nxt(tx);
   endtask

   task automatic bad(input logic [9:0] w);
      cyc(1, 0, 1, w);
      tx = nxt(tx);
   endtask

   initial begin
      logic [9:0] flip;
      int r;
      rst = 1'b1; en = 1'b0; clr = 1'b0; valid = 1'b0; win = '0;
      model_reset();

      // Reset with random inputs, then enabled but idle input.
      repeat (3) do_reset();
      repeat (10) cyc(1, 0, 0, 10'($urandom));
      check("idle_no_lock", 32'(lk16), 32'd0);

      // Clean acquisition from 0x001: locks on the fifth valid word (0x012).
      tx = 10'h001;
      repeat (4) good();
      check("acq_4_not_locked", 32'(lk16), 32'd0);
      good();
      check("acq_5_locked", 32'(lk16), 32'd1);
      check("acq_no_words", 32'(wc16), 32'd0);

      // Single-bit corruption: 0x025 sent instead of 0x024.
      bad(10'h025);
      check("flip_err", 32'(er16), 32'd1);
      check("flip_wc", 32'(wc16), 32'd1);
      check("flip_bc", 32'(bc16), 32'd1);
      repeat (6) begin
         cyc(1, 0, 0, 10'($urandom));
         good();
      end
      check("after_flip_wc", 32'(wc16), 32'd1);
      check("after_flip_lock", 32'(lk16), 32'd1);

      // Clear, then four 0x3FF words drop lock on the fourth.
      cyc(1, 1, 1, tx); tx = nxt(tx);
      check("clear_wc", 32'(wc16), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         bad(10'h3FF);
         check($sformatf("allones_err%0d", i), 32'(er16), 32'd1);
         check($sformatf("allones_lock%0d", i), 32'(lk16), (i < 4) ? 32'd1 : 32'd0);
      end
      check("allones_wc", 32'(wc16), 32'd4);

      // Relock after five clean words.
      repeat (4) good();
      check("relock_4", 32'(lk16), 32'd0);
      good();
      check("relock_5", 32'(lk16), 32'd1);

      // Disable, then zero words never lock; a zero mid-acquisition restarts the count.
      cyc(0, 0, 0, '0);
      check("disable_unlock", 32'(lk16), 32'd0);
      cyc(1, 0, 0, '0);
      repeat (8) cyc(1, 0, 1, 10'd0);
      check("zeros_no_lock", 32'(lk16), 32'd0);
      repeat (3) good();
      cyc(1, 0, 1, 10'd0);
      repeat (4) good();
      check("zero_restart_4", 32'(lk16), 32'd0);
      good();
      check("zero_restart_5", 32'(lk16), 32'd1);

      // Saturation: 20 three-bit errors, each followed by a good word to stay locked.
      cyc(1, 1, 1, tx); tx = nxt(tx);
      repeat (20) begin
         int a, b, c;
         a = $urandom_range(0, 9);
         b = (a + $urandom_range(1, 4)) % 10;
         c = (a + $urandom_range(5, 9)) % 10;
         flip = '0; flip[a] = 1'b1; flip[b] = 1'b1; flip[c] = 1'b1;
         bad(tx ^ flip);
         good();
      end
      check("sat_wc4", 32'(wc4), 32'd15);
      check("sat_bc4", 32'(bc4), 32'd15);
      check("sat_wc16", 32'(wc16), 32'd20);
      check("sat_bc16", 32'(bc16), 32'd60);

      // Clear on a mismatch cycle: counters cleared, ChkErr still pulses.
      cyc(1, 1, 1, tx ^ 10'h001); tx = nxt(tx);
      check("clr_mis_err", 32'(er16), 32'd1);
      check("clr_mis_wc", 32'(wc16), 32'd0);
      check("clr_mis_bc4", 32'(bc4), 32'd0);

      // Randomized traffic.
      repeat (400) begin
         bit e, c, v;
         logic [9:0] w;
         r = $urandom_range(0, 99);
         e = (r >= 3);
         c = ($urandom_range(0, 99) < 2);
         v = ($urandom_range(0, 99) < 70);
         r = $urandom_range(0, 99);
         if (r < 80)      w = tx;
         else if (r < 90) w = 10'($urandom);
         else if (r < 95) w = 10'd0;
         else             w = tx ^ 10'($urandom_range(1, 1023));
         cyc(e, c, v, w);
         if (v) tx = nxt(tx);
      end

      // Reset aborts an established lock.
      cyc(1, 0, 0, '0);
      repeat (6) good();
      check("pre_reset_lock", 32'(lk16), 32'd1);
      do_reset();
      check("reset_unlock", 32'(lk16), 32'd0);
      repeat (6) good();
      check("post_reset_lock", 32'(lk16), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
